axi4_stream_pkt_limiter: RTL and testbench
==========================================

AXI4_STREAM_PKT_LIMITER -- requirements
Module: axi4_stream_pkt_limiter

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, giving the tdata width in bits (multiple of 8).
REQ-002 The block SHALL have parameter USER_WIDTH, default 1, giving the tuser width.
REQ-003 The block SHALL have parameter DEST_WIDTH, default 1, giving the tdest width.
REQ-004 The block SHALL have parameter ID_WIDTH, default 1, giving the tid width.
REQ-005 The block SHALL have parameter MAX_PKT_WORDS, default 256, giving the maximum forwarded packet length in words (>= 1).
REQ-006 The block SHALL have port clk_i, input, width 1: the single clock.
REQ-007 The block SHALL have port rst_n_i, input, width 1: reset, asynchronous and active-low.
REQ-008 The block SHALL have port pkt_i, axi4_stream_if.slave: the input stream (tdata, tstrb, tkeep, tlast, tuser, tdest, tid, tvalid, tready).
REQ-009 The block SHALL have port pkt_o, axi4_stream_if.master: the output stream, same fields; it feeds the packet-dropping single-clock FIFO.
REQ-010 The block SHALL have port trunc_o, output, width 1: one-cycle pulse when a packet is truncated.
REQ-011 The block SHALL have port pkt_cnt_o, output, width 32: number of packets forwarded (tlast handshakes on pkt_o).
REQ-012 The block SHALL have port trunc_cnt_o, output, width 32: number of truncated packets.

Function
REQ-013 The block SHALL forward pkt_i to pkt_o through one output register stage: latency is 1 cycle from an accepted input word to pkt_o.tvalid.
REQ-014 The block SHALL drive pkt_i.tready = !pkt_o.tvalid || pkt_o.tready in state PASS, giving full throughput with no bubbles.
REQ-015 The output register SHALL hold all pkt_o fields stable while pkt_o.tvalid=1 and pkt_o.tready=0.
REQ-016 The block SHALL implement two states, PASS (reset state) and DISCARD.
REQ-017 In PASS, the block SHALL count accepted words of the current packet in a counter of width $clog2(MAX_PKT_WORDS+1); the counter resets to 0 on an accepted tlast word.
REQ-018 In PASS, the accepted word numbered MAX_PKT_WORDS (1-based) with pkt_i.tlast=0 SHALL be forwarded with tlast forced to 1 and tuser[0] forced to 1, all other fields unchanged.
REQ-019 On the truncation event of REQ-018, the block SHALL pulse trunc_o for 1 cycle, increment trunc_cnt_o, and enter DISCARD.
REQ-020 The word numbered MAX_PKT_WORDS with pkt_i.tlast=1 SHALL pass unmodified, with no truncation.
REQ-021 In DISCARD, pkt_i.tready SHALL be 1 and accepted words SHALL NOT be written to the output register; the output register continues to drain normally.
REQ-022 In DISCARD, an accepted word with tlast=1 SHALL return the FSM to PASS with the word counter at 0; the next accepted word is word 1 of a new packet.
REQ-023 With MAX_PKT_WORDS=1, every multi-word packet SHALL be reduced to its first word, marked per REQ-018.
REQ-024 pkt_cnt_o SHALL increment on each pkt_o handshake with tlast=1, including forced tlast.
REQ-025 Both 32-bit counters SHALL wrap from 0xFFFFFFFF to 0.
REQ-026 Words that are not truncated SHALL pass tuser unmodified.
REQ-027 Input tvalid=1 with tready=0 SHALL NOT advance any counter or state.

Reset
REQ-028 Asserting rst_n_i=0 SHALL asynchronously set the state to PASS and clear the word counter, pkt_o.tvalid, trunc_o, pkt_cnt_o and trunc_cnt_o to 0.
REQ-029 Reset asserted mid-packet or mid-DISCARD SHALL discard the held output word; the first word accepted after reset release is treated as word 1 of a packet.
REQ-030 pkt_i.tready SHALL be 0 while rst_n_i=0.

Verification
REQ-031 MAX_PKT_WORDS=4, a 3-word packet, pkt_o.tready=1 -> 3 words out unchanged, 1-cycle latency; pkt_cnt_o=1, trunc_cnt_o=0.
REQ-032 MAX_PKT_WORDS=4, a 4-word packet with tlast on word 4 -> forwarded unmodified; trunc_o stays 0.
REQ-033 MAX_PKT_WORDS=4, a 7-word packet (data 0..6) followed by a 2-word packet -> output data 0,1,2,3 with tlast and tuser[0]=1 on word 3; words 4..6 consumed with tready=1; the 2-word packet follows intact; trunc_cnt_o=1, pkt_cnt_o=2.
REQ-034 Random pkt_o.tready backpressure (50%) on 100 random-length packets of 1..10 words -> no data loss or duplication against the model; pkt_o fields stable while stalled.
REQ-035 rst_n_i pulsed low during DISCARD of a 9-word packet -> all outputs 0 immediately; the next packet is forwarded from word 1 unmodified.
REQ-036 MAX_PKT_WORDS=1, packets of 1, 3 and 1 words -> 3 single-word outputs, the second with tuser[0]=1; trunc_cnt_o=1.

Source files
------------

// File: rtl/axi4_stream_pkt_limiter_if.sv
// AXI4-Stream bundle shared by the packet limiter and its neighbours.
// Master drives payload and tvalid; slave drives tready.
interface axi4_stream_if #(
    parameter int DATA_WIDTH = 32,
    parameter int USER_WIDTH = 1,
    parameter int DEST_WIDTH = 1,
    parameter int ID_WIDTH   = 1
);
    logic [DATA_WIDTH-1:0]   tdata;
    logic [DATA_WIDTH/8-1:0] tstrb;
    logic [DATA_WIDTH/8-1:0] tkeep;
    logic                    tlast;
    logic [USER_WIDTH-1:0]   tuser;
    logic [DEST_WIDTH-1:0]   tdest;
    logic [ID_WIDTH-1:0]     tid;
    logic                    tvalid;
    logic                    tready;

    modport master (
        output tdata, tstrb, tkeep, tlast, tuser, tdest, tid, tvalid,
        input  tready
    );

    modport slave (
        input  tdata, tstrb, tkeep, tlast, tuser, tdest, tid, tvalid,
        output tready
    );
endinterface

// File: rtl/axi4_stream_pkt_limiter.sv
// Caps AXI4-Stream packets at MAX_PKT_WORDS; overlong packets get forced tlast/tuser[0] and their tail dropped.
// Latency: 1 cycle (single output register).
// Backpressure: pkt_o.tready stalls input while PASSing; the dropped tail is always accepted.
module axi4_stream_pkt_limiter #(
    parameter int DATA_WIDTH    = 32,
    parameter int USER_WIDTH    = 1,
    parameter int DEST_WIDTH    = 1,
    parameter int ID_WIDTH      = 1,
    parameter int MAX_PKT_WORDS = 256
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    axi4_stream_if.slave        pkt_i,
    axi4_stream_if.master       pkt_o,
    output logic                trunc_o,
    output logic [31:0]         pkt_cnt_o,
    output logic [31:0]         trunc_cnt_o
);
    localparam int KW = DATA_WIDTH / 8;
    localparam int CW = $clog2(MAX_PKT_WORDS + 1);
    localparam logic [CW-1:0] LAST_IDX = CW'(MAX_PKT_WORDS - 1);

    typedef enum logic {
        PASS    = 1'b0,
        DISCARD = 1'b1
    } state_e;

    state_e                state_q, state_d;
    logic [CW-1:0]         wcnt_q, wcnt_d;
    logic                  vld_q, vld_d;
    logic [DATA_WIDTH-1:0] tdata_q;
    logic [KW-1:0]         tstrb_q, tkeep_q;
    logic                  tlast_q;
    logic [USER_WIDTH-1:0] tuser_q, tuser_d;
    logic [DEST_WIDTH-1:0] tdest_q;
    logic [ID_WIDTH-1:0]   tid_q;
    logic                  trunc_q;
    logic [31:0]           pkt_cnt_q, trunc_cnt_q;

    logic in_rdy, in_hs, out_hs, load, force_eop;

    // Tready is held low during reset so nothing is swallowed while the FSM is forced to PASS.
    assign in_rdy = rst_n_i && ((state_q == DISCARD) || !vld_q || pkt_o.tready);
    assign in_hs  = pkt_i.tvalid && in_rdy;
    assign out_hs = vld_q && pkt_o.tready;

    always_comb begin
        state_d   = state_q;
        wcnt_d    = wcnt_q;
        load      = 1'b0;
        force_eop = 1'b0;
        if (in_hs) begin
            case (state_q)
                PASS: begin
                    load = 1'b1;
                    if (pkt_i.tlast) begin
                        wcnt_d = '0;
                    end else if (wcnt_q == LAST_IDX) begin
                        force_eop = 1'b1;
                        wcnt_d    = '0;
                        state_d   = DISCARD;
                    end else begin
                        wcnt_d = wcnt_q + CW'(1);
                    end
                end
                DISCARD: begin
                    if (pkt_i.tlast) begin
                        wcnt_d  = '0;
                        state_d = PASS;
                    end
                end
                default: state_d = PASS;
            endcase
        end
    end

    always_comb begin
        tuser_d    = pkt_i.tuser;
        tuser_d[0] = pkt_i.tuser[0] | force_eop;
        vld_d      = vld_q;
        if (load) begin
            vld_d = 1'b1;
        end else if (out_hs) begin
            vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= PASS;
            wcnt_q      <= '0;
            vld_q       <= 1'b0;
            tdata_q     <= '0;
            tstrb_q     <= '0;
            tkeep_q     <= '0;
            tlast_q     <= 1'b0;
            tuser_q     <= '0;
            tdest_q     <= '0;
            tid_q       <= '0;
            trunc_q     <= 1'b0;
            pkt_cnt_q   <= '0;
            trunc_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            vld_q   <= vld_d;
            trunc_q <= force_eop;
            if (load) begin
                tdata_q <= pkt_i.tdata;
                tstrb_q <= pkt_i.tstrb;
                tkeep_q <= pkt_i.tkeep;
                tlast_q <= pkt_i.tlast | force_eop;
                tuser_q <= tuser_d;
                tdest_q <= pkt_i.tdest;
                tid_q   <= pkt_i.tid;
            end
            if (force_eop) begin
                trunc_cnt_q <= trunc_cnt_q + 32'd1;
            end
            if (out_hs && tlast_q) begin
                pkt_cnt_q <= pkt_cnt_q + 32'd1;
            end
        end
    end

    assign pkt_i.tready = in_rdy;
    assign pkt_o.tvalid = vld_q;
    assign pkt_o.tdata  = tdata_q;
    assign pkt_o.tstrb  = tstrb_q;
    assign pkt_o.tkeep  = tkeep_q;
    assign pkt_o.tlast  = tlast_q;
    assign pkt_o.tuser  = tuser_q;
    assign pkt_o.tdest  = tdest_q;
    assign pkt_o.tid    = tid_q;
    assign trunc_o      = trunc_q;
    assign pkt_cnt_o    = pkt_cnt_q;
    assign trunc_cnt_o  = trunc_cnt_q;
endmodule

// File: tb/tb_axi4_stream_pkt_limiter.sv
// Scoreboard bench: u4 (MAX_PKT_WORDS=4) and u1 (MAX_PKT_WORDS=1) share one driver; a model predicts each output word.
`timescale 1ns/1ps
module tb_axi4_stream_pkt_limiter;
    typedef struct packed {
        logic [31:0] dat;
        logic [3:0]  strb;
        logic [3:0]  keep;
        logic        last;
        logic        user;
        logic        dest;
        logic        id;
    } word_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    axi4_stream_if in4 ();
    axi4_stream_if out4 ();
    axi4_stream_if in1 ();
    axi4_stream_if out1 ();

    logic        d_vld = 1'b0, d_last = 1'b0, d_user = 1'b0, sel = 1'b0, o_rdy = 1'b1;
    logic [31:0] d_dat = '0;
    logic        tr4, tr1;
    logic [31:0] pc4, tc4, pc1, tc1;

    assign in4.tvalid = d_vld & ~sel;
    assign in1.tvalid = d_vld & sel;
    assign in4.tdata = d_dat;        assign in1.tdata = d_dat;
    assign in4.tstrb = d_dat[7:4];   assign in1.tstrb = d_dat[7:4];
    assign in4.tkeep = d_dat[3:0];   assign in1.tkeep = d_dat[3:0];
    assign in4.tlast = d_last;       assign in1.tlast = d_last;
    assign in4.tuser = d_user;       assign in1.tuser = d_user;
    assign in4.tdest = d_dat[8];     assign in1.tdest = d_dat[8];
    assign in4.tid   = d_dat[9];     assign in1.tid   = d_dat[9];
    assign out4.tready = o_rdy;
    assign out1.tready = o_rdy;

    axi4_stream_pkt_limiter #(.MAX_PKT_WORDS(4)) u4 (
        .clk_i(clk), .rst_n_i(rst_n), .pkt_i(in4), .pkt_o(out4),
        .trunc_o(tr4), .pkt_cnt_o(pc4), .trunc_cnt_o(tc4)
    );
    axi4_stream_pkt_limiter #(.MAX_PKT_WORDS(1)) u1 (
        .clk_i(clk), .rst_n_i(rst_n), .pkt_i(in1), .pkt_o(out1),
        .trunc_o(tr1), .pkt_cnt_o(pc1), .trunc_cnt_o(tc1)
    );

    int total = 0;
    int bad = 0;
    int cyc = 0;
    bit lat_on = 1'b0;
    bit rnd_rdy = 1'b0;

    word_t q4[$], q1[$];
    int    a4[$], a1[$];
    int    m_cnt[2], m_max[2], exp_pkts[2], exp_trunc[2], seen_trunc[2];
    bit    m_disc[2], stall_v[2];
    word_t stall_w[2];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic word_t mk(input logic [31:0] dat, input logic last, input logic user);
        word_t w;
        w.dat = dat; w.strb = dat[7:4]; w.keep = dat[3:0];
        w.last = last; w.user = user; w.dest = dat[8]; w.id = dat[9];
        return w;
    endfunction

    task automatic model_reset();
        for (int s = 0; s < 2; s++) begin
            m_cnt[s] = 0; m_disc[s] = 1'b0; exp_pkts[s] = 0;
            exp_trunc[s] = 0; seen_trunc[s] = 0; stall_v[s] = 1'b0;
        end
        q4.delete(); q1.delete(); a4.delete(); a1.delete();
    endtask

    task automatic model_accept(input int s, input word_t w, input int acc);
        if (!m_disc[s]) begin
            m_cnt[s]++;
            if (!w.last && m_cnt[s] == m_max[s]) begin
                w.last = 1'b1; w.user = 1'b1;
                m_disc[s] = 1'b1; exp_trunc[s]++;
            end
            if (w.last) begin
                m_cnt[s] = 0; exp_pkts[s]++;
            end
            if (s == 0) begin q4.push_back(w); a4.push_back(acc); end
            else        begin q1.push_back(w); a1.push_back(acc); end
        end else if (w.last) begin
            m_disc[s] = 1'b0; m_cnt[s] = 0;
        end
    endtask

    // Called at a negedge; returns at the negedge following acceptance with tvalid still high.
    task automatic send_word(input int s, input logic [31:0] dat, input logic last, input logic user);
        bit done = 1'b0;
        sel = (s == 1); d_dat = dat; d_last = last; d_user = user; d_vld = 1'b1;
        for (int i = 0; i < 1000 && !done; i++) begin
            #4;
            if (s == 1 ? in1.tready : in4.tready) begin
                model_accept(s, mk(dat, last, user), cyc);
                done = 1'b1;
            end
            @(negedge clk);
        end
        if (!done) chk("hs_timeout", 64'd0, 64'd1);
    endtask

    task automatic idle(input int n);
        d_vld = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_pkt(input int s, input logic [31:0] base, input int len, input logic user);
        for (int i = 0; i < len; i++) send_word(s, base + i, (i == len - 1), user);
        idle(1);
    endtask

    task automatic drain();
        int n = 0;
        idle(1);
        while ((q4.size() + q1.size()) != 0 && n < 500) begin
            @(negedge clk); n++;
        end
        chk("drain_left", 64'(q4.size() + q1.size()), 64'd0);
        idle(2);
    endtask

    task automatic chk_cnts(input string tag);
        chk({tag, "_pkt4"}, pc4, 64'(exp_pkts[0]));
        chk({tag, "_trc4"}, tc4, 64'(exp_trunc[0]));
        chk({tag, "_pls4"}, 64'(seen_trunc[0]), 64'(exp_trunc[0]));
        chk({tag, "_pkt1"}, pc1, 64'(exp_pkts[1]));
        chk({tag, "_trc1"}, tc1, 64'(exp_trunc[1]));
        chk({tag, "_pls1"}, 64'(seen_trunc[1]), 64'(exp_trunc[1]));
    endtask

    task automatic mon_step(input int s, input logic vld, input logic rdy, input word_t w, input logic trunc);
        word_t e;
        int    acc;
        if (!rst_n) begin
            stall_v[s] = 1'b0;
        end else begin
            if (trunc) seen_trunc[s]++;
            if (stall_v[s] && vld) chk(s == 0 ? "stable4" : "stable1", w, stall_w[s]);
            if (vld && rdy) begin
                if ((s == 0 ? q4.size() : q1.size()) == 0) begin
                    chk(s == 0 ? "extra4" : "extra1", 64'd1, 64'd0);
                end else begin
                    if (s == 0) begin e = q4.pop_front(); acc = a4.pop_front(); end
                    else        begin e = q1.pop_front(); acc = a1.pop_front(); end
                    chk(s == 0 ? "word4" : "word1", w, e);
                    if (lat_on) chk(s == 0 ? "lat4" : "lat1", 64'(cyc - acc), 64'd1);
                end
            end
            stall_v[s] = vld && !rdy;
            stall_w[s] = w;
        end
    endtask

    always @(negedge clk) begin
        if (rnd_rdy) o_rdy = 1'($urandom_range(0, 1));
        #4;
        mon_step(0, out4.tvalid, out4.tready,
                 {out4.tdata, out4.tstrb, out4.tkeep, out4.tlast, out4.tuser[0], out4.tdest[0], out4.tid[0]}, tr4);
        mon_step(1, out1.tvalid, out1.tready,
                 {out1.tdata, out1.tstrb, out1.tkeep, out1.tlast, out1.tuser[0], out1.tdest[0], out1.tid[0]}, tr1);
    end

    initial begin
        m_max[0] = 4; m_max[1] = 1;
        model_reset();
        #1;
        chk("rst_vld4", out4.tvalid, 64'd0);
        chk("rst_rdy4", in4.tready, 64'd0);
        chk("rst_trunc4", tr4, 64'd0);
        chk("rst_pkt4", pc4, 64'd0);
        chk("rst_trc4", tc4, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // 3-word packet, 4-word packet with tlast at the limit, 7-word then 2-word.
        lat_on = 1'b1;
        send_pkt(0, 32'h0000_0110, 3, 1'b0);
        drain();
        chk_cnts("p3");
        send_pkt(0, 32'h0000_0220, 4, 1'b0);
        drain();
        chk_cnts("p4");
        send_pkt(0, 32'h0000_0000, 7, 1'b0);
        send_pkt(0, 32'h0000_0330, 2, 1'b0);
        drain();
        chk_cnts("p7");

        // Random lengths with 50% output backpressure and input gaps.
        lat_on = 1'b0;
        rnd_rdy = 1'b1;
        for (int p = 0; p < 100; p++) begin
            int len = $urandom_range(1, 10);
            logic u = 1'($urandom_range(0, 1));
            for (int i = 0; i < len; i++) begin
                send_word(0, (p << 12) | (i << 4) | 32'($urandom_range(0, 15)), (i == len - 1), u);
                if ($urandom_range(0, 9) < 3) idle(1);
            end
        end
        rnd_rdy = 1'b0;
        o_rdy = 1'b1;
        drain();
        chk_cnts("rand");

        // Reset while discarding the tail of a 9-word packet.
        lat_on = 1'b1;
        for (int i = 0; i < 6; i++) send_word(0, 32'h0000_0500 + i, 1'b0, 1'b0);
        idle(1);
        rst_n = 1'b0;
        #1;
        chk("mid_vld4", out4.tvalid, 64'd0);
        chk("mid_rdy4", in4.tready, 64'd0);
        chk("mid_trunc4", tr4, 64'd0);
        chk("mid_pkt4", pc4, 64'd0);
        chk("mid_trc4", tc4, 64'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send_pkt(0, 32'h0000_0600, 3, 1'b0);
        drain();
        chk_cnts("post_rst");

        // Limit of one word: 1, 3, 1.
        send_pkt(1, 32'h0000_0700, 1, 1'b0);
        send_pkt(1, 32'h0000_0710, 3, 1'b0);
        send_pkt(1, 32'h0000_0720, 1, 1'b0);
        drain();
        chk_cnts("max1");
        chk("max1_pkts", pc1, 64'd3);
        chk("max1_trunc", tc1, 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
